// File: rtl/game_disp_pkg.sv
// Shared definitions for the game display output path.
//   NUM_DIGITS    : number of multiplexed 7-segment digits
//   SEG_BLANK     : segment value with every segment dark (active-low)
//   AN_OFF        : anode value with every digit disabled (active-low)
//   digit_idx_t   : index of the digit currently being scanned
//   slot_phase_t  : phase within one digit slot (BLANK, then ACTIVE)
//   an_onehot_low : active-low anode pattern that selects a single digit
package game_disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        PH_BLANK  = 1'b0,
        PH_ACTIVE = 1'b1
    } slot_phase_t;

    function automatic logic [3:0] an_onehot_low(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timing for the digit scanner.
// Each digit owns a slot of SLOT_CYCLES clocks. The first BLANK_CYCLES clocks of
// a slot are the BLANK phase (all anodes off, prevents ghosting of the previous
// digit's pattern); the remainder is the ACTIVE phase.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   digit        : digit owning the current slot (0..3)
//   active       : 1 during the ACTIVE phase of the slot
//   slot_start   : 1 during the first cycle of every slot
//   frame_start  : 1 during the first cycle of slot 0
module seg_slot_timer
    import game_disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    output digit_idx_t digit,
    output logic       active,
    output logic       slot_start,
    output logic       frame_start
);

    localparam int               CNT_W      = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_end;
    slot_phase_t      phase;
    slot_phase_t      phase_nxt;

    assign slot_end = (slot_cnt == SLOT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_BLANK;
        end else begin
            phase <= phase_nxt;
        end
    end

    // The phase register tracks (slot_cnt >= BLANK_CYCLES): it flips to ACTIVE
    // on the edge that moves slot_cnt to BLANK_CYCLES and back to BLANK on wrap.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_BLANK:  if (slot_cnt == BLANK_LAST) phase_nxt = PH_ACTIVE;
            PH_ACTIVE: if (slot_end)               phase_nxt = PH_BLANK;
            default:                               phase_nxt = PH_BLANK;
        endcase
    end

    assign active      = (phase == PH_ACTIVE);
    assign slot_start  = (slot_cnt == '0);
    assign frame_start = slot_start & (digit == 2'd0);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit 7-segment display.
// Scans seg0..seg3 onto the shared seg/an pins one digit per slot, with a blank
// gap at the start of each slot, per-digit blink and 16-level brightness PWM.
// Pattern, brightness and blink state are captured once per slot so changes on
// the inputs never tear a digit mid-slot.
// Ports:
//   Clk100M     : system clock
//   reset       : asynchronous active-high reset
//   seg0..seg3  : per-digit active-low patterns {dp,g..a}; seg0 is the rightmost
//   blink_mask  : bit d set makes digit d blink
//   blink_phase : 1 = blinking digits dark
//   brightness  : 0 = off .. 15 = full on
//   seg         : segment pins, active-low
//   an          : anode enables, active-low, an[d] drives digit d
//   frame_tick  : one-cycle pulse at the first cycle of slot 0 of each frame
module seg_scan_driver
    import game_disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [3:0] blink_mask,
    input  logic       blink_phase,
    input  logic [3:0] brightness,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_param_check
            $error("seg_scan_driver: need 1 <= BLANK_CYCLES < SLOT_CYCLES");
        end
    endgenerate

    digit_idx_t digit;
    logic       active;
    logic       slot_start;
    logic       frame_start;

    logic [7:0] cur_pat;
    logic [7:0] hold_pat;
    logic [3:0] hold_bri;
    logic       hold_dark;
    logic [3:0] pwm_cnt;
    logic       lit;

    seg_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk        (Clk100M),
        .reset      (reset),
        .digit      (digit),
        .active     (active),
        .slot_start (slot_start),
        .frame_start(frame_start)
    );

    always_comb begin
        cur_pat = SEG_BLANK;
        case (digit)
            2'd0:    cur_pat = seg0;
            2'd1:    cur_pat = seg1;
            2'd2:    cur_pat = seg2;
            2'd3:    cur_pat = seg3;
            default: cur_pat = SEG_BLANK;
        endcase
    end

    // Snapshot on the first cycle of the slot. That cycle is always BLANK, so
    // the hold registers being one cycle late there is never visible.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            hold_pat  <= SEG_BLANK;
            hold_bri  <= '0;
            hold_dark <= 1'b0;
            pwm_cnt   <= '0;
        end else if (slot_start) begin
            hold_pat  <= cur_pat;
            hold_bri  <= brightness;
            hold_dark <= blink_mask[digit] & blink_phase;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 4'd1;
        end
    end

    // Level 15 is special-cased so full brightness has no dark PWM cycle.
    assign lit = active & ~hold_dark & ((hold_bri == 4'hF) | (pwm_cnt < hold_bri));

    // Registered outputs: seg is forced blank whenever no anode is enabled.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= lit ? hold_pat : SEG_BLANK;
            an         <= lit ? an_onehot_low(digit) : AN_OFF;
            frame_tick <= frame_start;
        end
    end

endmodule
